writeback_unit: RTL and testbench

Drives the register file's write port (write register number, write value, op strobe) from two result producers, the ALU and the load/store unit. It arbitrates between them with a starvation guard and retires one result per cycle as a one-cycle write strobe. It also keeps a per-register pending-write scoreboard so decode can stall on RAW hazards. It sits between execute/memory and the register file, as the writer counterpart to the register file's read/write ports.

---
 rtl/writeback_unit_pkg.sv | 8 +
 rtl/writeback_unit_arbiter.sv | 34 +++
 rtl/writeback_unit.sv | 99 +++++++++
 tb/tb_writeback_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared widths and limits for the writeback unit and its register-file scoreboard.
package writeback_unit_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int SB_CNT_W   = 2;
  localparam int SB_CNT_MAX = 3;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
endpackage

// File: rtl/writeback_unit_arbiter.sv
// Two-request arbiter: LSU has priority, and the ALU is forced through after
// STARVE_LIMIT consecutive losses. Readies are combinational.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_alu_valid,
  input  logic i_lsu_valid,
  output logic o_alu_ready,
  output logic o_lsu_ready,
  output logic o_grant_alu
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic          w_forced;

  assign w_forced    = i_alu_valid && (r_starve == SW'(STARVE_LIMIT));
  assign o_alu_ready = i_alu_valid && (w_forced || !i_lsu_valid);
  assign o_lsu_ready = i_lsu_valid && !w_forced;
  assign o_grant_alu = o_alu_ready;

  // Saturation is implicit: at the limit the ALU always wins and the count clears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (i_alu_valid && !o_alu_ready) begin
      r_starve <= r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end
endmodule

// File: rtl/writeback_unit.sv
// Retires one ALU/LSU result per cycle into the register-file write port and
// tracks per-register pending writes so decode can stall on RAW hazards.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN         = writeback_unit_pkg::XLEN,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  output logic                  o_issue_ready,
  input  logic [REG_ADDR_W-1:0] i_chk_rs1,
  input  logic [REG_ADDR_W-1:0] i_chk_rs2,
  output logic                  o_busy_rs1,
  output logic                  o_busy_rs2,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_val,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_val,
  output logic                  o_lsu_ready,
  output logic                  o_w_op,
  output logic [REG_ADDR_W-1:0] o_w_reg_num,
  output logic [XLEN-1:0]       o_w_val
);
  logic                  w_grant_alu;
  logic                  w_accept;
  logic [REG_ADDR_W-1:0] w_acc_rd;
  logic [XLEN-1:0]       w_acc_val;
  logic                  w_inc_fire;

  logic                  r_w_op;
  logic [REG_ADDR_W-1:0] r_w_reg_num;
  logic [XLEN-1:0]       r_w_val;
  logic [SB_CNT_W-1:0]   r_cnt [NUM_REGS];

  wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_alu_valid (i_alu_valid),
    .i_lsu_valid (i_lsu_valid),
    .o_alu_ready (o_alu_ready),
    .o_lsu_ready (o_lsu_ready),
    .o_grant_alu (w_grant_alu)
  );

  assign w_accept  = o_alu_ready || o_lsu_ready;
  assign w_acc_rd  = w_grant_alu ? i_alu_rd  : i_lsu_rd;
  assign w_acc_val = w_grant_alu ? i_alu_val : i_lsu_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w_op      <= 1'b0;
      r_w_reg_num <= '0;
      r_w_val     <= '0;
    end else begin
      // x0 results are consumed but never strobe the register file.
      r_w_op <= w_accept && (w_acc_rd != '0);
      if (w_accept) begin
        r_w_reg_num <= w_acc_rd;
        r_w_val     <= w_acc_val;
      end
    end
  end

  assign o_w_op      = r_w_op;
  assign o_w_reg_num = r_w_reg_num;
  assign o_w_val     = r_w_val;

  assign o_issue_ready = (i_issue_rd == '0) ||
                         (r_cnt[i_issue_rd] != SB_CNT_W'(SB_CNT_MAX));
  assign w_inc_fire    = i_issue_valid && o_issue_ready && (i_issue_rd != '0);
  assign o_busy_rs1    = (r_cnt[i_chk_rs1] != '0);
  assign o_busy_rs2    = (r_cnt[i_chk_rs2] != '0);

  // Entry 0 is only ever written by reset, which keeps x0 permanently idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        case ({w_inc_fire && (i_issue_rd == REG_ADDR_W'(i)),
               r_w_op && (r_w_reg_num == REG_ADDR_W'(i))})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A retiring write must always have a matching pending entry.
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_w_op |-> (r_cnt[r_w_reg_num] != '0));
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized
// run against a pending-count / arbitration reference model.
module tb_writeback_unit;
  localparam int XLEN = 32;
  localparam int LIM  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      chk_rs1, chk_rs2;
  logic            busy_rs1, busy_rs2;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_val;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_val;
  logic            lsu_ready;
  logic            w_op;
  logic [4:0]      w_reg_num;
  logic [XLEN-1:0] w_val;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
    .i_chk_rs1(chk_rs1), .i_chk_rs2(chk_rs2), .o_busy_rs1(busy_rs1), .o_busy_rs2(busy_rs2),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_val(alu_val), .o_alu_ready(alu_ready),
    .i_lsu_valid(lsu_valid), .i_lsu_rd(lsu_rd), .i_lsu_val(lsu_val), .o_lsu_ready(lsu_ready),
    .o_w_op(w_op), .o_w_reg_num(w_reg_num), .o_w_val(w_val)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_val = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_val = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd;
    tick();
    issue_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    issue_rd = 5; chk_rs1 = 5; chk_rs2 = 31;
    rst_n = 0;
    #2;
    checks++;
    if ({w_op, w_reg_num, w_val} !== {1'b0, 5'd0, 32'd0}) begin
      failures++; $display("FAIL reset_wport got=%0h/%0h/%0h exp=0/0/0", w_op, w_reg_num, w_val);
    end
    checks++;
    if ({busy_rs1, busy_rs2, issue_ready, alu_ready, lsu_ready} !== 5'b00100) begin
      failures++; $display("FAIL reset_flags got=%b exp=00100", {busy_rs1, busy_rs2, issue_ready, alu_ready, lsu_ready});
    end
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    checks++;
    if ({w_op, busy_rs1, issue_ready} !== 3'b001) begin
      failures++; $display("FAIL reset_after_release got=%b exp=001", {w_op, busy_rs1, issue_ready});
    end
  endtask

  task automatic test_alu_basic();
    do_reset();
    chk_rs1 = 5;
    issue(5);
    alu_valid = 1; alu_rd = 5; alu_val = 32'hDEADBEEF;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin
      failures++; $display("FAIL alu_basic_ready got=%b exp=10", {alu_ready, lsu_ready});
    end
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if ({w_op, w_reg_num, w_val, busy_rs1} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
      failures++; $display("FAIL alu_basic_write got=%0h/%0h/%0h busy=%0b exp=1/5/deadbeef busy=1", w_op, w_reg_num, w_val, busy_rs1);
    end
    tick();
    checks++;
    if ({w_op, busy_rs1} !== 2'b00) begin
      failures++; $display("FAIL alu_basic_after got=%b exp=00", {w_op, busy_rs1});
    end
  endtask

  task automatic test_starvation();
    do_reset();
    issue(3);
    repeat (3) issue(4);
    issue_valid = 1; issue_rd = 4;
    for (int k = 0; k <= LIM + 1; k++) begin
      alu_valid = 1; alu_rd = 3; alu_val = 32'hA000_0000 + k;
      lsu_valid = 1; lsu_rd = 4; lsu_val = 32'hB000_0000 + k;
      #1;
      checks++;
      if ({alu_ready, lsu_ready} !== ((k == LIM) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL starve_grant cyc=%0d got=%b exp=%b", k, {alu_ready, lsu_ready}, (k == LIM) ? 2'b10 : 2'b01);
      end
      tick();
      checks++;
      if ({w_op, w_reg_num, w_val} !== ((k == LIM) ? {1'b1, 5'd3, 32'hA000_0000 + k} : {1'b1, 5'd4, 32'hB000_0000 + k})) begin
        failures++; $display("FAIL starve_write cyc=%0d got=%0h/%0h/%0h", k, w_op, w_reg_num, w_val);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_sb_saturate();
    do_reset();
    chk_rs1 = 7;
    for (int j = 0; j < 3; j++) begin
      issue_valid = 1; issue_rd = 7;
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
        failures++; $display("FAIL sat_issue_ready n=%0d got=%b exp=1", j, issue_ready);
      end
      tick();
    end
    #1;
    checks++;
    if ({issue_ready, busy_rs1} !== 2'b01) begin
      failures++; $display("FAIL sat_full got=%b exp=01", {issue_ready, busy_rs1});
    end
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_val = 32'h70;
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if ({w_op, issue_ready} !== 2'b10) begin
      failures++; $display("FAIL sat_no_bypass got=%b exp=10", {w_op, issue_ready});
    end
    tick();
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++; $display("FAIL sat_ready_back got=%b exp=1", issue_ready);
    end
    alu_valid = 1; alu_val = 32'h71;
    tick();
    alu_val = 32'h72;
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if ({w_op, w_reg_num, w_val, busy_rs1} !== {1'b1, 5'd7, 32'h72, 1'b1}) begin
      failures++; $display("FAIL sat_last_write got=%0h/%0h/%0h busy=%0b exp=1/7/72 busy=1", w_op, w_reg_num, w_val, busy_rs1);
    end
    tick();
    checks++;
    if ({w_op, busy_rs1} !== 2'b00) begin
      failures++; $display("FAIL sat_busy_clear got=%b exp=00", {w_op, busy_rs1});
    end
  endtask

  task automatic test_incdec_same();
    do_reset();
    chk_rs1 = 9;
    issue(9);
    alu_valid = 1; alu_rd = 9; alu_val = 32'h99;
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 9;
    #1;
    checks++;
    if ({w_op, w_reg_num, issue_ready} !== {1'b1, 5'd9, 1'b1}) begin
      failures++; $display("FAIL incdec_cycle got=%0h/%0h/%0h exp=1/9/1", w_op, w_reg_num, issue_ready);
    end
    tick();
    issue_valid = 0;
    #1;
    checks++;
    if (busy_rs1 !== 1'b1) begin
      failures++; $display("FAIL incdec_busy got=%b exp=1", busy_rs1);
    end
    alu_valid = 1;
    tick();
    alu_valid = 0;
    tick();
    checks++;
    if (busy_rs1 !== 1'b0) begin
      failures++; $display("FAIL incdec_drain got=%b exp=0", busy_rs1);
    end
  endtask

  task automatic test_x0();
    do_reset();
    issue(2);
    chk_rs1 = 0; chk_rs2 = 2;
    alu_valid = 1; alu_rd = 0; alu_val = 32'h1234;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      failures++; $display("FAIL x0_ready got=%b exp=1", alu_ready);
    end
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 0;
    #1;
    checks++;
    if ({w_op, w_reg_num, w_val, issue_ready} !== {1'b0, 5'd0, 32'h1234, 1'b1}) begin
      failures++; $display("FAIL x0_write got=%0h/%0h/%0h rdy=%0b exp=0/0/1234 rdy=1", w_op, w_reg_num, w_val, issue_ready);
    end
    tick();
    issue_valid = 0;
    tick();
    checks++;
    if ({busy_rs1, busy_rs2, w_op} !== 3'b010) begin
      failures++; $display("FAIL x0_scoreboard got=%b exp=010", {busy_rs1, busy_rs2, w_op});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(10);
    issue(11);
    chk_rs1 = 11; chk_rs2 = 10;
    alu_valid = 1; alu_rd = 10; alu_val = 32'hCAFE;
    tick();
    alu_valid = 0;
    issue_rd = 11;
    checks++;
    if ({w_op, busy_rs1, busy_rs2} !== 3'b111) begin
      failures++; $display("FAIL midrst_before got=%b exp=111", {w_op, busy_rs1, busy_rs2});
    end
    rst_n = 0;
    #1;
    checks++;
    if ({w_op, busy_rs1, busy_rs2, issue_ready} !== 4'b0001) begin
      failures++; $display("FAIL midrst_after got=%b exp=0001", {w_op, busy_rs1, busy_rs2, issue_ready});
    end
    @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    int pend[32];
    int owed[32];
    int starve_m;
    logic e_op;
    logic [4:0] e_reg;
    logic [XLEN-1:0] e_val;
    logic exp_ir, forced, alu_win, lsu_win;
    int r;
    do_reset();
    for (int i = 0; i < 32; i++) begin pend[i] = 0; owed[i] = 0; end
    starve_m = 0; e_op = 0; e_reg = 0; e_val = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if ({w_op, w_reg_num, w_val} !== {e_op, e_reg, e_val}) begin
        failures++; $display("FAIL rand_wport cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, w_op, w_reg_num, w_val, e_op, e_reg, e_val);
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      chk_rs1 = 5'($urandom_range(0, 7));
      chk_rs2 = 5'($urandom_range(0, 7));
      alu_valid = 0;
      lsu_valid = 0;
      r = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0 && (r == 0 || owed[r] > 0)) begin
        alu_valid = 1; alu_rd = 5'(r); alu_val = $urandom;
      end
      r = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0 && (r == 0 || owed[r] > 0)) begin
        lsu_valid = 1; lsu_rd = 5'(r); lsu_val = $urandom;
      end
      #1;
      exp_ir  = (issue_rd == 0) || (pend[issue_rd] < 3);
      forced  = alu_valid && (starve_m == LIM);
      alu_win = alu_valid && (forced || !lsu_valid);
      lsu_win = lsu_valid && !alu_win;
      checks++;
      if ({alu_ready, lsu_ready, issue_ready} !== {alu_win, lsu_win, exp_ir}) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, {alu_ready, lsu_ready, issue_ready}, {alu_win, lsu_win, exp_ir});
      end
      checks++;
      if ({busy_rs1, busy_rs2} !== {pend[chk_rs1] > 0, pend[chk_rs2] > 0}) begin
        failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, {busy_rs1, busy_rs2}, {pend[chk_rs1] > 0, pend[chk_rs2] > 0});
      end
      if (e_op) pend[e_reg]--;
      if (issue_valid && exp_ir && issue_rd != 0) begin
        pend[issue_rd]++; owed[issue_rd]++;
      end
      starve_m = (alu_valid && !alu_win) ? starve_m + 1 : 0;
      e_op = 0;
      if (alu_win) begin
        e_reg = alu_rd; e_val = alu_val; e_op = (alu_rd != 0);
      end else if (lsu_win) begin
        e_reg = lsu_rd; e_val = lsu_val; e_op = (lsu_rd != 0);
      end
      if (e_op) owed[e_reg]--;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_basic();
    test_starvation();
    test_sb_saturate();
    test_incdec_same();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
